// File: rtl/sequence_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_recorder
//  Description : Records a burst of words into an external single-port RAM
//                and plays them back one word per rate-divider tick.
//                The RAM returns read data one clock after the address.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_recorder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic              play_start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              tick,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              busy,
    output logic              play_done
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_RECORD    = 3'd1;
    localparam logic [2:0] c_PLAY_REQ  = 3'd2;
    localparam logic [2:0] c_PLAY_WAIT = 3'd3;
    localparam logic [2:0] c_PLAY_OUT  = 3'd4;

    // Pointer and length carry one extra bit so a full RAM reads as 2^ADDR_W.
    localparam logic [ADDR_W:0] c_CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_ZERO     = '0;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_length;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_play_done;
    logic              w_full;
    logic              w_write;
    logic [ADDR_W:0]   w_ptr_inc;

    assign w_full    = (r_length == c_CAPACITY);
    assign w_ptr_inc = r_ptr + c_ONE;

    // Reset gates the write strobe so an abort mid-record never writes.
    assign w_write = (r_state == c_RECORD) && din_valid && !w_full && !reset;

    // The pointer addresses the RAM in every state; it only moves when a
    // write lands or a word is emitted, so the read address is stable
    // across PLAY_REQ and PLAY_WAIT.
    assign ram_address = r_ptr[ADDR_W-1:0];
    assign ram_data    = din;
    assign ram_wren    = w_write;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign length      = r_length;
    assign full        = w_full;
    assign busy        = (r_state != c_IDLE);
    assign play_done   = r_play_done;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; rec_start wins over a simultaneous play_start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (rec_start) begin
                    w_next_state = c_RECORD;
                end else if (play_start && (r_length != c_ZERO)) begin
                    w_next_state = c_PLAY_REQ;
                end
            end
            c_RECORD: begin
                if (rec_stop) begin
                    w_next_state = c_IDLE;
                end
            end
            c_PLAY_REQ: begin
                if (tick) begin
                    w_next_state = c_PLAY_WAIT;
                end
            end
            c_PLAY_WAIT: begin
                w_next_state = c_PLAY_OUT;
            end
            c_PLAY_OUT: begin
                if (w_ptr_inc == r_length) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_next_state = c_PLAY_REQ;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Pointer, length, playback output register and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr        <= c_ZERO;
            r_length     <= c_ZERO;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_play_done  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_play_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (rec_start) begin
                        r_ptr    <= c_ZERO;
                        r_length <= c_ZERO;
                    end else if (play_start) begin
                        if (r_length == c_ZERO) begin
                            r_play_done <= 1'b1;
                        end else begin
                            r_ptr <= c_ZERO;
                        end
                    end
                end
                c_RECORD: begin
                    if (w_write) begin
                        r_ptr    <= w_ptr_inc;
                        r_length <= r_length + c_ONE;
                    end
                end
                c_PLAY_WAIT: begin
                    // ram_q is valid now, so dout and its strobe are
                    // presented throughout the PLAY_OUT cycle.
                    r_dout       <= ram_q;
                    r_dout_valid <= 1'b1;
                end
                c_PLAY_OUT: begin
                    r_ptr <= w_ptr_inc;
                    if (w_ptr_inc == r_length) begin
                        r_play_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequence_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_recorder
//  Description : Directed self-checking bench for sequence_recorder with a
//                behavioural one-clock-latency RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_recorder;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 20;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rec_start = 1'b0;
    logic              rec_stop = 1'b0;
    logic              play_start = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              tick = 1'b0;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W:0]   length;
    logic              full;
    logic              busy;
    logic              play_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mem [0:31];
    int                wr_count = 0;
    logic [ADDR_W-1:0] wr_addr [0:255];
    int                dv_count = 0;
    logic [DATA_W-1:0] dv_log [0:255];
    int                pd_count = 0;

    sequence_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .play_start (play_start),
        .din        (din),
        .din_valid  (din_valid),
        .tick       (tick),
        .ram_q      (ram_q),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .dout       (dout),
        .dout_valid (dout_valid),
        .length     (length),
        .full       (full),
        .busy       (busy),
        .play_done  (play_done)
    );

    always #5 clock = ~clock;

    // Behavioural RAM: synchronous write, registered read.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    // Event logs.
    always @(posedge clock) begin
        if (ram_wren && wr_count < 256) begin
            wr_addr[wr_count] = ram_address;
            wr_count = wr_count + 1;
        end
        if (dout_valid && dv_count < 256) begin
            dv_log[dv_count] = dout;
            dv_count = dv_count + 1;
        end
        if (play_done) pd_count = pd_count + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rec_words(input int n, input logic [DATA_W-1:0] base);
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            din = base + DATA_W'(i); din_valid = 1'b1; cyc();
        end
        din_valid = 1'b0; rec_stop = 1'b1; cyc(); rec_stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc();
        n_checks++; if (length !== 6'd0) begin n_fail++; $display("FAIL reset_length: got %0d expected 0", length); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dout !== 20'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 00000", dout); end
        n_checks++; if ({dout_valid, play_done, ram_wren, full} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {dout_valid, play_done, ram_wren, full}); end
        reset = 1'b0; cyc();
    endtask

    task automatic test_record3();
        logic [DATA_W-1:0] w [3];
        int base;
        w[0] = 20'h00001; w[1] = 20'h00002; w[2] = 20'hFFFFF;
        base = wr_count;
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rec3_busy: got %b expected 1", busy); end
        for (int i = 0; i < 3; i++) begin
            din = w[i]; din_valid = 1'b1; #1;
            n_checks++; if (ram_wren !== 1'b1 || ram_address !== 5'(i) || ram_data !== w[i]) begin n_fail++; $display("FAIL rec3_write%0d: got wren=%b addr=%0d data=%h expected wren=1 addr=%0d data=%h", i, ram_wren, ram_address, ram_data, i, w[i]); end
            cyc();
        end
        din_valid = 1'b0; rec_stop = 1'b1; cyc(); rec_stop = 1'b0;
        n_checks++; if (length !== 6'd3) begin n_fail++; $display("FAIL rec3_length: got %0d expected 3", length); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rec3_idle: got busy=%b expected 0", busy); end
        n_checks++; if (wr_count - base !== 3) begin n_fail++; $display("FAIL rec3_wrcount: got %0d expected 3", wr_count - base); end
    endtask

    task automatic test_play3();
        logic [DATA_W-1:0] w [3];
        int dvb;
        w[0] = 20'h00001; w[1] = 20'h00002; w[2] = 20'hFFFFF;
        play_start = 1'b1; cyc(); play_start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL play3_busy: got %b expected 1", busy); end
        for (int k = 0; k < 3; k++) begin
            repeat (10) cyc();
            n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL play3_idle_dv%0d: got %b expected 0", k, dout_valid); end
            tick = 1'b1; cyc(); tick = 1'b0;
            n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL play3_early_dv%0d: got %b expected 0", k, dout_valid); end
            cyc();
            n_checks++; if (dout_valid !== 1'b1 || dout !== w[k]) begin n_fail++; $display("FAIL play3_word%0d: got dv=%b dout=%h expected dv=1 dout=%h", k, dout_valid, dout, w[k]); end
            cyc();
            n_checks++; if (dout_valid !== 1'b0 || play_done !== (k == 2)) begin n_fail++; $display("FAIL play3_after%0d: got dv=%b done=%b expected dv=0 done=%b", k, dout_valid, play_done, (k == 2)); end
        end
        n_checks++; if (busy !== 1'b0 || dout !== 20'hFFFFF) begin n_fail++; $display("FAIL play3_end: got busy=%b dout=%h expected busy=0 dout=fffff", busy, dout); end
        dvb = dv_count;
        tick = 1'b1; cyc(); tick = 1'b0; repeat (3) cyc();
        n_checks++; if (dv_count !== dvb || dout !== 20'hFFFFF) begin n_fail++; $display("FAIL idle_tick: got dv_pulses=%0d dout=%h expected 0 dout=fffff", dv_count - dvb, dout); end
    endtask

    task automatic test_empty_play();
        int dvb;
        reset = 1'b1; cyc(); reset = 1'b0;
        dvb = dv_count;
        play_start = 1'b1; cyc(); play_start = 1'b0;
        n_checks++; if (play_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_done: got done=%b busy=%b expected done=1 busy=0", play_done, busy); end
        cyc();
        n_checks++; if (play_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_after: got done=%b busy=%b expected done=0 busy=0", play_done, busy); end
        repeat (3) cyc();
        n_checks++; if (dv_count !== dvb) begin n_fail++; $display("FAIL empty_dv: got %0d pulses expected 0", dv_count - dvb); end
    endtask

    task automatic test_reset_mid_record();
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        din = 20'h12345; din_valid = 1'b1; reset = 1'b1; #1;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rstrec_wren_cycle: got %b expected 0", ram_wren); end
        cyc(); reset = 1'b0; #1;
        n_checks++; if (ram_wren !== 1'b0 || busy !== 1'b0 || length !== 6'd0) begin n_fail++; $display("FAIL rstrec_after: got wren=%b busy=%b len=%0d expected 0 0 0", ram_wren, busy, length); end
        din_valid = 1'b0; cyc();
    endtask

    task automatic test_full();
        int base;
        int bad;
        base = wr_count;
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int i = 0; i < 34; i++) begin
            din = 20'h00100 + DATA_W'(i); din_valid = 1'b1; #1;
            n_checks++; if (full !== (i >= 32) || ram_wren !== (i < 32)) begin n_fail++; $display("FAIL full_word%0d: got full=%b wren=%b expected full=%b wren=%b", i, full, ram_wren, (i >= 32), (i < 32)); end
            cyc();
        end
        din_valid = 1'b0;
        n_checks++; if (length !== 6'd32 || full !== 1'b1) begin n_fail++; $display("FAIL full_length: got len=%0d full=%b expected 32 1", length, full); end
        bad = 0;
        for (int i = 0; i < 32; i++) if (wr_addr[base + i] !== 5'(i)) bad++;
        n_checks++; if (wr_count - base !== 32 || bad !== 0) begin n_fail++; $display("FAIL full_writes: got count=%0d bad_addr=%0d expected 32 0", wr_count - base, bad); end
        rec_stop = 1'b1; cyc(); rec_stop = 1'b0;
        n_checks++; if (busy !== 1'b0 || length !== 6'd32) begin n_fail++; $display("FAIL full_stop: got busy=%b len=%0d expected 0 32", busy, length); end
    endtask

    task automatic test_play_full();
        int dvb, pdb, budget, bad;
        dvb = dv_count; pdb = pd_count; budget = 0;
        tick = 1'b1; play_start = 1'b1; cyc(); play_start = 1'b0;
        while (pd_count == pdb && budget < 300) begin cyc(); budget++; end
        tick = 1'b0;
        n_checks++; if (pd_count == pdb) begin n_fail++; $display("FAIL playfull_timeout: got no play_done expected play_done within 300 cycles"); end
        bad = 0;
        for (int i = 0; i < 32; i++) if (dv_log[dvb + i] !== 20'h00100 + DATA_W'(i)) bad++;
        n_checks++; if (dv_count - dvb !== 32 || bad !== 0) begin n_fail++; $display("FAIL playfull_words: got count=%0d bad=%0d expected 32 0", dv_count - dvb, bad); end
        cyc();
        n_checks++; if (busy !== 1'b0 || dout !== 20'h0011F) begin n_fail++; $display("FAIL playfull_end: got busy=%b dout=%h expected 0 0011f", busy, dout); end
    endtask

    task automatic test_reset_mid_play();
        int dvb;
        reset = 1'b1; cyc(); reset = 1'b0;
        rec_words(5, 20'hA0000);
        play_start = 1'b1; cyc(); play_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
            n_checks++; if (dout_valid !== 1'b1 || dout !== 20'hA0000 + DATA_W'(k)) begin n_fail++; $display("FAIL rstplay_word%0d: got dv=%b dout=%h expected dv=1 dout=%h", k, dout_valid, dout, 20'hA0000 + DATA_W'(k)); end
            cyc();
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || length !== 6'd0 || dout !== 20'h0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstplay_state: got busy=%b len=%0d dout=%h dv=%b expected 0 0 00000 0", busy, length, dout, dout_valid); end
        dvb = dv_count;
        repeat (5) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc(); end
        n_checks++; if (dv_count !== dvb) begin n_fail++; $display("FAIL rstplay_no_dv: got %0d pulses expected 0", dv_count - dvb); end
    endtask

    task automatic test_simultaneous();
        rec_words(2, 20'h00055);
        rec_start = 1'b1; play_start = 1'b1; cyc(); rec_start = 1'b0; play_start = 1'b0;
        n_checks++; if (busy !== 1'b1 || length !== 6'd0) begin n_fail++; $display("FAIL simul_state: got busy=%b len=%0d expected 1 0", busy, length); end
        din = 20'h0BEEF; din_valid = 1'b1; #1;
        n_checks++; if (ram_wren !== 1'b1 || ram_address !== 5'd0) begin n_fail++; $display("FAIL simul_record: got wren=%b addr=%0d expected 1 0", ram_wren, ram_address); end
        rec_stop = 1'b1; cyc(); din_valid = 1'b0; rec_stop = 1'b0;
        n_checks++; if (busy !== 1'b0 || length !== 6'd1) begin n_fail++; $display("FAIL simul_stop: got busy=%b len=%0d expected 0 1", busy, length); end
    endtask

    initial begin
        test_reset();
        test_record3();
        test_play3();
        test_empty_play();
        test_reset_mid_record();
        test_full();
        test_play_full();
        test_reset_mid_play();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sequence_recorder.md
SEQUENCE_RECORDER -- requirements
Module: sequence_recorder

Interface
REQ-001 Parameter: ADDR_W, 5, RAM address width; capacity = 2^ADDR_W = 32 words.
REQ-002 Parameter: DATA_W, 20, RAM word width.
REQ-003 Port: clock  in  1  single system clock, all logic on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: rec_start  in  1  one-cycle pulse: begin recording at address 0.
REQ-006 Port: rec_stop  in  1  one-cycle pulse: end recording.
REQ-007 Port: play_start  in  1  one-cycle pulse: begin playback of recorded words.
REQ-008 Port: din  in  DATA_W  word to record.
REQ-009 Port: din_valid  in  1  din is to be stored this cycle.
REQ-010 Port: tick  in  1  rate-divider enable; one playback word per tick.
REQ-011 Port: ram_q  in  DATA_W  RAM read data, valid one clock after ram_address.
REQ-012 Port: ram_address  out  ADDR_W  RAM address.
REQ-013 Port: ram_data  out  DATA_W  RAM write data.
REQ-014 Port: ram_wren  out  1  RAM write enable.
REQ-015 Port: dout  out  DATA_W  played-back word, held between outputs.
REQ-016 Port: dout_valid  out  1  one-cycle pulse when dout updates.
REQ-017 Port: length  out  ADDR_W+1  number of stored words, 0..32.
REQ-018 Port: full  out  1  length == 32.
REQ-019 Port: busy  out  1  state != IDLE.
REQ-020 Port: play_done  out  1  one-cycle pulse after the last word is played.

Function
REQ-021 The block SHALL implement states IDLE, RECORD, PLAY_REQ, PLAY_WAIT, PLAY_OUT.
REQ-022 In IDLE, rec_start SHALL clear length to 0, set the address pointer to 0 and enter RECORD; rec_start SHALL take priority over a simultaneous play_start.
REQ-023 In RECORD, din_valid with full low SHALL assert ram_wren, drive ram_data=din and ram_address=pointer combinationally in the same cycle, and increment pointer and length at the next edge.
REQ-024 In RECORD, din_valid while full is high SHALL be ignored (no write, no counter change).
REQ-025 In RECORD, rec_stop SHALL return to IDLE; if din_valid is also high in that cycle, the word SHALL be written first (subject to REQ-024).
REQ-026 ram_wren SHALL be low in every state other than RECORD.
REQ-027 In IDLE, play_start with length==0 SHALL pulse play_done on the next cycle and remain in IDLE.
REQ-028 In IDLE, play_start with length>0 SHALL set pointer to 0 and enter PLAY_REQ.
REQ-029 PLAY_REQ SHALL wait for tick, then drive ram_address=pointer and enter PLAY_WAIT.
REQ-030 PLAY_WAIT SHALL last exactly one cycle and cover the RAM read latency; the next state is PLAY_OUT.
REQ-031 PLAY_OUT SHALL register dout<=ram_q, pulse dout_valid for one cycle and increment pointer.
REQ-032 From PLAY_OUT, if the incremented pointer equals length, the block SHALL pulse play_done and enter IDLE; otherwise it SHALL return to PLAY_REQ.
REQ-033 tick pulses arriving outside PLAY_REQ SHALL be ignored; a word is emitted at most once per tick, with latency tick -> dout_valid of 2 clocks.
REQ-034 Pointer arithmetic SHALL be ADDR_W+1 bits so length reaches 32 without wrapping; ram_address SHALL be pointer[ADDR_W-1:0].
REQ-035 rec_start, rec_stop and play_start SHALL be ignored in states where they are not listed above; recording never overwrites during playback.
REQ-036 dout SHALL hold its last value until the next PLAY_OUT.

Reset
REQ-037 When reset is high at a clock edge, the block SHALL enter IDLE with length=0, pointer=0, dout=0, and dout_valid, play_done and ram_wren at 0, overriding all other inputs.
REQ-038 Reset asserted mid-RECORD or mid-PLAY SHALL abort immediately; ram_wren SHALL be 0 in the reset cycle and in the following cycle.

Verification
REQ-039 Record 3 words 0x00001, 0x00002, 0xFFFFF, then rec_stop -> writes at addresses 0,1,2; length=3; busy=0.
REQ-040 play_start, then 3 ticks spaced 10 clocks apart -> dout_valid pulses 2 clocks after each tick with dout 0x00001, 0x00002, 0xFFFFF; play_done pulses after the third word.
REQ-041 Write 34 valid words -> 32 writes (addresses 0..31), full=1 after the 32nd, words 33-34 dropped, length=32.
REQ-042 play_start with length=0 -> play_done pulses next cycle, dout_valid never asserts, busy stays 0.
REQ-043 Reset after the 2nd of 5 playback ticks -> IDLE, length=0, dout=0, no further dout_valid.
REQ-044 rec_start and play_start asserted in the same IDLE cycle -> enters RECORD with length=0.
